// File: rtl/banked_fifo_pkg.sv
// Shared definitions for the banked single-port-RAM FIFO.
package banked_fifo_pkg;

    // Entries in the output prefetch buffer that hides the RAM read latency.
    localparam int OBUF_DEPTH = 2;

    // Per-bank access request for one cycle: a write wins over a read.
    typedef struct packed {
        logic wr_en;
        logic rd_en;
    } bank_req_t;

    // Bank that holds word address addr (num_banks is a power of 2).
    function automatic int bank_of(input int addr, input int num_banks);
        return addr & (num_banks - 1);
    endfunction

endpackage

// File: rtl/banked_spram_fifo_if.sv
// Stream interface of the banked FIFO: write side, read side and status.
// Handshake: a word moves on a cycle where valid && ready are both high at the
// rising edge; valid never depends on ready, and data/valid on the read side
// hold steady while valid && !ready.
interface banked_spram_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 6
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [CNT_W-1:0]      count;
    logic                  almost_full;
    logic                  almost_empty;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, count, almost_full, almost_empty
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, count, almost_full, almost_empty
    );
endinterface

// File: rtl/spram_bank.sv
// Single-port RAM bank: one access per cycle, 1-cycle read latency,
// rdata holds the last value read.
module spram_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_W      = 4
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ROW_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ROW_W];

    // Write or registered read on the single port.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end
endmodule

// File: rtl/banked_spram_fifo.sv
// FIFO over NUM_BANKS single-port RAM banks (word i in bank i % NUM_BANKS),
// with a 2-entry prefetch buffer in front of the read port.
// Optional statistics (max_count, conflict_cnt, stats_clr) when
// BANKED_FIFO_STATS_EN is defined.
module banked_spram_fifo
    import banked_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 32,
    parameter int NUM_BANKS   = 2,
    parameter int AF_LEVEL    = FIFO_DEPTH - 2,
    parameter int AE_LEVEL    = 2,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    banked_spram_fifo_if.slave    bus
`ifdef BANKED_FIFO_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [CNT_W-1:0]      max_count,
    output logic [15:0]           conflict_cnt
`endif
);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = ADDR_W - BANK_W;

    logic [ADDR_W-1:0]     waddr, raddr;
    logic [CNT_W-1:0]      count_q, count_next, ram_cnt, count_o;
    logic                  inflight;
    logic [BANK_W-1:0]     inflight_bank;
    logic [DATA_WIDTH-1:0] obuf [OBUF_DEPTH];
    logic                  obuf_rd, obuf_wr;
    logic [1:0]            obuf_cnt;
    logic [2:0]            pend;
    logic                  push, pop, rd_want, rd_blocked, rd_issue;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    assign push = bus.wr_valid && bus.wr_ready;
    assign pop  = bus.rd_valid && bus.rd_ready;

    // Prefetch only if the word would still fit in the buffer once it lands;
    // a write to the same bank this cycle defers the read by one cycle.
    assign pend       = 3'(obuf_cnt) + 3'(inflight) - 3'(pop);
    assign rd_want    = (ram_cnt != '0) && (pend < 3'd2);
    assign rd_blocked = rd_want && push && (waddr[BANK_W-1:0] == raddr[BANK_W-1:0]);
    assign rd_issue   = rd_want && !rd_blocked;
    assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bank_req_t req;

        // Route this cycle's write or prefetch read to the owning bank.
        always_comb begin
            req.wr_en = push     && (bank_of(int'(waddr), NUM_BANKS) == b);
            req.rd_en = rd_issue && (bank_of(int'(raddr), NUM_BANKS) == b);
        end

        spram_bank #(.DATA_WIDTH(DATA_WIDTH), .ROW_W(ROW_W)) u_bank (
            .clk   (clk),
            .en    (req.wr_en || req.rd_en),
            .we    (req.wr_en),
            .addr  (req.wr_en ? waddr[ADDR_W-1:BANK_W] : raddr[ADDR_W-1:BANK_W]),
            .wdata (bus.wr_data),
            .rdata (bank_rdata[b])
        );
    end

    // Pointers, occupancy and the prefetch buffer; reset drops in-flight data.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr         <= '0;
            raddr         <= '0;
            count_q       <= '0;
            ram_cnt       <= '0;
            inflight      <= 1'b0;
            inflight_bank <= '0;
            obuf_rd       <= 1'b0;
            obuf_wr       <= 1'b0;
            obuf_cnt      <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) obuf[i] <= '0;
        end else begin
            if (push)     waddr <= waddr + 1'b1;
            if (rd_issue) raddr <= raddr + 1'b1;
            count_q       <= count_next;
            ram_cnt       <= ram_cnt + CNT_W'(push) - CNT_W'(rd_issue);
            inflight      <= rd_issue;
            inflight_bank <= raddr[BANK_W-1:0];
            if (inflight) begin
                obuf[obuf_wr] <= bank_rdata[inflight_bank];
                obuf_wr       <= ~obuf_wr;
            end
            if (pop) obuf_rd <= ~obuf_rd;
            obuf_cnt <= obuf_cnt + 2'(inflight) - 2'(pop);
        end
    end

    assign count_o          = rst ? '0 : count_q;
    assign bus.count        = count_o;
    assign bus.wr_ready     = !rst && (count_q < CNT_W'(FIFO_DEPTH));
    assign bus.rd_valid     = !rst && (obuf_cnt != '0);
    assign bus.rd_data      = rst ? '0 : obuf[obuf_rd];
    assign bus.almost_full  = count_o >= CNT_W'(AF_LEVEL);
    assign bus.almost_empty = count_o <= CNT_W'(AE_LEVEL);

`ifdef BANKED_FIFO_STATS_EN
    // Peak occupancy and saturating count of deferred reads.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            max_count    <= '0;
            conflict_cnt <= '0;
        end else begin
            if (count_next > max_count) max_count <= count_next;
            if (rd_blocked && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif
endmodule
